chunk_argmax_streamer: RTL and testbench

CHUNK_ARGMAX_STREAMER -- requirements
Module: chunk_argmax_streamer

---
 rtl/chunk_argmax_streamer_if.sv | 29 ++
 rtl/chunk_argmax_streamer.sv | 119 +++++++++++
 tb/tb_chunk_argmax_streamer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/chunk_argmax_streamer_if.sv
// Handshake bundle for chunk_argmax_streamer: vector input side and per-chunk result side.
interface chunk_argmax_streamer_if #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned LANES           = 16,
  parameter int unsigned LANE_IDX_WIDTH  = 4,
  parameter int unsigned NUM_CHUNKS      = 8,
  parameter int unsigned CHUNK_CNT_WIDTH = 3
);
  logic                                in_valid;
  logic                                in_ready;
  logic [WIDTH*LANES*NUM_CHUNKS-1:0]   in_data;
  logic                                out_valid;
  logic                                out_ready;
  logic signed [WIDTH-1:0]             out_max;
  logic [LANE_IDX_WIDTH-1:0]           out_argmax;
  logic [CHUNK_CNT_WIDTH-1:0]          out_chunk;
  logic                                out_first;
  logic                                out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_max, out_argmax, out_chunk, out_first, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_max, out_argmax, out_chunk, out_first, out_last
  );
endinterface

// File: rtl/chunk_argmax_streamer.sv
// Accepts a vector of signed elements and streams one {max, argmax} result per chunk,
// first-occurrence on ties, with ready/valid backpressure on the result side.
module chunk_argmax_streamer #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned LANES           = 16,
  parameter int unsigned LANE_IDX_WIDTH  = 4,
  parameter int unsigned NUM_CHUNKS      = 8,
  parameter int unsigned CHUNK_CNT_WIDTH = 3
) (
  input logic                    clk,
  input logic                    rst,
  chunk_argmax_streamer_if.slave bus
);
  localparam int unsigned ChunkBits = WIDTH * LANES;
  localparam logic [CHUNK_CNT_WIDTH-1:0] LastChunk = CHUNK_CNT_WIDTH'(NUM_CHUNKS - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e                           state_q;
  logic [WIDTH*LANES*NUM_CHUNKS-1:0] buf_q;
  logic [CHUNK_CNT_WIDTH-1:0]       ptr_q;
  logic                             last_loaded_q;
  logic                             out_valid_q;
  logic signed [WIDTH-1:0]          out_max_q;
  logic [LANE_IDX_WIDTH-1:0]        out_argmax_q;
  logic [CHUNK_CNT_WIDTH-1:0]       out_chunk_q;
  logic                             out_first_q;
  logic                             out_last_q;

  logic [ChunkBits-1:0]       chunk_sel;
  logic signed [WIDTH-1:0]    red_max;
  logic signed [WIDTH-1:0]    lane_val;
  logic [LANE_IDX_WIDTH-1:0]  red_idx;
  logic                       accept;
  logic                       load_stream;
  logic                       load;
  logic [CHUNK_CNT_WIDTH-1:0] load_ptr;
  logic                       is_last;
  logic                       xfer_last;

  // Chunk 0 is reduced straight from in_data on the acceptance edge so the first
  // result appears one cycle after acceptance.
  always_comb begin
    if (state_q == StIdle) begin
      chunk_sel = bus.in_data[ChunkBits-1:0];
    end else begin
      chunk_sel = buf_q[int'(ptr_q) * ChunkBits +: ChunkBits];
    end
  end

  always_comb begin
    red_max  = $signed(chunk_sel[WIDTH-1:0]);
    red_idx  = '0;
    lane_val = '0;
    for (int l = 1; l < int'(LANES); l++) begin
      lane_val = $signed(chunk_sel[l*WIDTH +: WIDTH]);
      if (lane_val > red_max) begin
        red_max = lane_val;
        red_idx = LANE_IDX_WIDTH'(l);
      end
    end
  end

  always_comb begin
    accept      = (state_q == StIdle) && bus.in_valid;
    load_stream = (state_q == StStream) && !last_loaded_q && (!out_valid_q || bus.out_ready);
    load        = accept || load_stream;
    load_ptr    = accept ? '0 : ptr_q;
    is_last     = (load_ptr == LastChunk);
    xfer_last   = out_valid_q && bus.out_ready && out_last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      last_loaded_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_max_q     <= {1'b1, {(WIDTH-1){1'b0}}};
      out_argmax_q  <= '0;
      out_chunk_q   <= '0;
      out_first_q   <= 1'b0;
      out_last_q    <= 1'b0;
    end else begin
      if (load) begin
        out_valid_q   <= 1'b1;
        out_max_q     <= red_max;
        out_argmax_q  <= red_idx;
        out_chunk_q   <= load_ptr;
        out_first_q   <= (load_ptr == '0);
        out_last_q    <= is_last;
        last_loaded_q <= is_last;
        ptr_q         <= is_last ? load_ptr : load_ptr + 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle:   if (accept) state_q <= StStream;
        StStream: if (xfer_last) state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  // Buffer carries no reset; it only ever changes on a real acceptance.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      buf_q <= bus.in_data;
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_max    = out_max_q;
  assign bus.out_argmax = out_argmax_q;
  assign bus.out_chunk  = out_chunk_q;
  assign bus.out_first  = out_first_q;
  assign bus.out_last   = out_last_q;
endmodule

// File: tb/tb_chunk_argmax_streamer.sv
// Directed and table-driven checks of chunk_argmax_streamer, plus a random global-argmax pass.
module tb_chunk_argmax_streamer;
  localparam int W  = 8;
  localparam int L  = 16;
  localparam int N  = 8;
  localparam int DW = W * L * N;

  logic clk = 1'b0;
  logic rst = 1'b1;

  chunk_argmax_streamer_if #(
    .WIDTH(W), .LANES(L), .LANE_IDX_WIDTH(4), .NUM_CHUNKS(N), .CHUNK_CNT_WIDTH(3)
  ) bus ();

  chunk_argmax_streamer #(
    .WIDTH(W), .LANES(L), .LANE_IDX_WIDTH(4), .NUM_CHUNKS(N), .CHUNK_CNT_WIDTH(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            emax[N];
    int            eidx[N];
  } vec_t;

  vec_t tbl[3];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " out_valid"}, bus.out_valid, 0);
    check({tag, " in_ready"}, bus.in_ready, 1);
    check({tag, " out_max"}, $signed(bus.out_max), -128);
    check({tag, " out_argmax"}, bus.out_argmax, 0);
    check({tag, " out_chunk"}, bus.out_chunk, 0);
    check({tag, " out_first"}, bus.out_first, 0);
    check({tag, " out_last"}, bus.out_last, 0);
  endtask

  // Leaves the bench at the sample point just after the acceptance edge.
  task automatic accept_vec(input logic [DW-1:0] d);
    int k = 0;
    while (!bus.in_ready && k < 50) begin
      step();
      k++;
    end
    check("in_ready before accept", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_chunks(input int emax[N], input int eidx[N], input int from,
                              input int to, input string tag);
    for (int c = from; c <= to; c++) begin
      check($sformatf("%s c%0d out_valid", tag, c), bus.out_valid, 1);
      check($sformatf("%s c%0d out_max", tag, c), $signed(bus.out_max), emax[c]);
      check($sformatf("%s c%0d out_argmax", tag, c), bus.out_argmax, eidx[c]);
      check($sformatf("%s c%0d out_chunk", tag, c), bus.out_chunk, c);
      check($sformatf("%s c%0d out_first", tag, c), bus.out_first, (c == 0) ? 1 : 0);
      check($sformatf("%s c%0d out_last", tag, c), bus.out_last, (c == N - 1) ? 1 : 0);
      check($sformatf("%s c%0d in_ready", tag, c), bus.in_ready, 0);
      step();
    end
    if (to == N - 1) begin
      check({tag, " end out_valid"}, bus.out_valid, 0);
      check({tag, " end in_ready"}, bus.in_ready, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    int base[N];
    int ref_max, ref_idx, got_max, got_idx, v;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Vector 0: one peak of 50+c per chunk, everything else -1.
    for (int k = 0; k < L * N; k++) tbl[0].data[k*W +: W] = 8'hFF;
    for (int c = 0; c < N; c++) begin
      tbl[0].data[(c*L + (c+3) % 16)*W +: W] = 8'(50 + c);
      tbl[0].emax[c] = 50 + c;
      tbl[0].eidx[c] = (c + 3) % 16;
    end

    // Vector 1: ties and extremes.
    base = '{-128, 0, 0, 5, -2, -128, 9, -128};
    for (int c = 0; c < N; c++)
      for (int l = 0; l < L; l++) tbl[1].data[(c*L + l)*W +: W] = 8'(base[c]);
    tbl[1].data[(1*L + 5)*W +: W]  = 8'(127);
    tbl[1].data[(1*L + 9)*W +: W]  = 8'(127);
    tbl[1].data[(2*L + 15)*W +: W] = 8'(1);
    tbl[1].data[(4*L + 0)*W +: W]  = 8'(-1);
    tbl[1].data[(5*L + 7)*W +: W]  = 8'(-100);
    tbl[1].data[(6*L + 3)*W +: W]  = 8'(10);
    tbl[1].data[(6*L + 12)*W +: W] = 8'(10);
    tbl[1].data[(7*L + 15)*W +: W] = 8'(-127);
    tbl[1].emax = '{-128, 127, 1, 5, -1, -100, 10, -127};
    tbl[1].eidx = '{0, 5, 15, 0, 0, 7, 3, 15};

    // Vector 2: every element equal.
    for (int k = 0; k < L * N; k++) tbl[2].data[k*W +: W] = 8'(7);
    tbl[2].emax = '{7, 7, 7, 7, 7, 7, 7, 7};
    tbl[2].eidx = '{0, 0, 0, 0, 0, 0, 0, 0};

    step();
    step();
    check_reset_state("reset held");
    rst = 1'b0;
    step();
    check_reset_state("after reset");

    for (int i = 0; i < 3; i++) begin
      accept_vec(tbl[i].data);
      check_chunks(tbl[i].emax, tbl[i].eidx, 0, N - 1, $sformatf("vec%0d", i));
    end

    // Back-to-back with in_valid held: the second vector must land on the 9th edge.
    bus.in_valid = 1'b1;
    bus.in_data  = tbl[0].data;
    step();
    bus.in_data = tbl[1].data;
    check_chunks(tbl[0].emax, tbl[0].eidx, 0, N - 1, "b2b A");
    step();
    bus.in_valid = 1'b0;
    check_chunks(tbl[1].emax, tbl[1].eidx, 0, N - 1, "b2b B");

    // Backpressure: stall three edges while chunk 2 is presented.
    accept_vec(tbl[0].data);
    check_chunks(tbl[0].emax, tbl[0].eidx, 0, 1, "bp");
    bus.out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("bp stall%0d out_valid", s), bus.out_valid, 1);
      check($sformatf("bp stall%0d out_chunk", s), bus.out_chunk, 2);
      check($sformatf("bp stall%0d out_max", s), $signed(bus.out_max), 52);
      check($sformatf("bp stall%0d out_argmax", s), bus.out_argmax, 5);
      check($sformatf("bp stall%0d in_ready", s), bus.in_ready, 0);
      step();
    end
    bus.out_ready = 1'b1;
    check_chunks(tbl[0].emax, tbl[0].eidx, 2, N - 1, "bp");

    // Mid-stream reset right after chunk 4 transfers.
    accept_vec(tbl[1].data);
    check_chunks(tbl[1].emax, tbl[1].eidx, 0, 4, "midrst");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("midrst after");
    step();
    check("midrst no result out_valid", bus.out_valid, 0);
    accept_vec(tbl[0].data);
    check_chunks(tbl[0].emax, tbl[0].eidx, 0, N - 1, "post rst");

    // Random vectors: global first-occurrence argmax from the chunk stream.
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < L * N; k++) begin
        if (r % 2 == 0) d[k*W +: W] = 8'($urandom_range(0, 255));
        else            d[k*W +: W] = 8'($urandom_range(0, 7) + 124);
      end
      ref_max = $signed(d[W-1:0]);
      ref_idx = 0;
      for (int k = 1; k < L * N; k++) begin
        v = $signed(d[k*W +: W]);
        if (v > ref_max) begin
          ref_max = v;
          ref_idx = k;
        end
      end
      accept_vec(d);
      got_max = 0;
      got_idx = -1;
      for (int c = 0; c < N; c++) begin
        check($sformatf("rand%0d c%0d out_valid", r, c), bus.out_valid, 1);
        v = $signed(bus.out_max);
        if (c == 0 || v > got_max) begin
          got_max = v;
          got_idx = int'(bus.out_chunk) * L + int'(bus.out_argmax);
        end
        step();
      end
      check($sformatf("rand%0d global idx", r), got_idx, ref_idx);
      check($sformatf("rand%0d global max", r), got_max, ref_max);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
